fft32_reorder: RTL and testbench

- Output-side companion to the 32-point pipelined FFT stage chain.
- Accepts the chain's dual-stream output (two complex samples per valid beat, bit-reversed bin order) and re-emits each frame in natural bin order, still two samples per beat.
- Ping-pong buffered, so sustained full-rate frames pass without stalls.
- Sits between the last FFT stage and spectrum consumers such as the magnitude and peak logic.

---
 rtl/fft32_reorder_pkg.sv | 13 +
 rtl/fft32_reorder_bank.sv | 24 ++
 rtl/fft32_reorder.sv | 79 +++++++
 tb/tb_fft32_reorder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft32_reorder_pkg.sv
// fft32_reorder_pkg: frame-size constants, log2n-bit bit-reversal helper and read-state encoding
package fft32_reorder_pkg;
  localparam int LOG2N = 5;
  localparam int N = 1 << LOG2N;
  localparam int NH = N / 2;
  typedef enum logic {IDLE, RUN} rd_state_t;
  function automatic logic [15:0] bitrev(input logic [15:0] a, input int bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < bits; i++) r[i] = a[bits-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft32_reorder_bank.sv
// fft32_reorder_bank: N-entry complex register bank; i_clk, dual write (i_we, i_wa0/1, i_wd0/1), dual read of entries 2*i_ra and 2*i_ra+1 (o_rd0/1)
module fft32_reorder_bank import fft32_reorder_pkg::*; #(
  parameter int width = 8,
  parameter int log2n = LOG2N
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [log2n-1:0]   i_wa0,
  input  logic [log2n-1:0]   i_wa1,
  input  logic [2*width-1:0] i_wd0,
  input  logic [2*width-1:0] i_wd1,
  input  logic [log2n-2:0]   i_ra,
  output logic [2*width-1:0] o_rd0,
  output logic [2*width-1:0] o_rd1
);
  logic [2*width-1:0] r_mem [1 << log2n];
  always_ff @(posedge i_clk)
    if (i_we) begin
      r_mem[i_wa0] <= i_wd0;
      r_mem[i_wa1] <= i_wd1;
    end
  assign o_rd0 = r_mem[{i_ra, 1'b0}];
  assign o_rd1 = r_mem[{i_ra, 1'b1}];
endmodule

// File: rtl/fft32_reorder.sv
// fft32_reorder: ping-pong bit-reversed to natural order reorder; CLK/RST/ce, beat in (valid_i, x*, y*), beat out (valid_o, sof_o, bin_o, x*_o, y*_o)
module fft32_reorder import fft32_reorder_pkg::*; #(
  parameter int width = 8,
  parameter int log2n = LOG2N
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce,
  input  logic             valid_i,
  input  logic [width-1:0] xr,
  input  logic [width-1:0] xi,
  input  logic [width-1:0] yr,
  input  logic [width-1:0] yi,
  output logic             valid_o,
  output logic             sof_o,
  output logic [log2n-2:0] bin_o,
  output logic [width-1:0] xr_o,
  output logic [width-1:0] xi_o,
  output logic [width-1:0] yr_o,
  output logic [width-1:0] yi_o
);
  localparam logic [log2n-2:0] LAST = '1;
  rd_state_t r_state, w_state_nx;
  logic [log2n-2:0] r_wcnt, r_rcnt, w_rcnt_nx;
  logic r_wbank, r_rbank, w_rbank_nx;
  logic w_wr, w_arm, w_rlast;
  logic [log2n-1:0] w_wa0, w_wa1;
  logic [2*width-1:0] w_rd0 [2];
  logic [2*width-1:0] w_rd1 [2];
  assign w_wr = ce & valid_i;
  assign w_arm = w_wr & (r_wcnt == LAST);
  assign w_rlast = (r_state == RUN) && (r_rcnt == LAST);
  assign w_wa0 = log2n'(bitrev(16'({r_wcnt, 1'b0}), log2n));
  assign w_wa1 = log2n'(bitrev(16'({r_wcnt, 1'b1}), log2n));
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft32_reorder_bank #(.width(width), .log2n(log2n)) u_bank (
      .i_clk(CLK),
      .i_we (w_wr & (r_wbank == 1'(b))),
      .i_wa0(w_wa0),
      .i_wa1(w_wa1),
      .i_wd0({xr, xi}),
      .i_wd1({yr, yi}),
      .i_ra (r_rcnt),
      .o_rd0(w_rd0[b]),
      .o_rd1(w_rd1[b])
    );
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_rbank <= 1'b0;
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
    end else if (ce) begin
      r_state <= w_state_nx;
      r_rcnt  <= w_rcnt_nx;
      r_rbank <= w_rbank_nx;
      if (valid_i) r_wcnt <= r_wcnt + 1'b1;
      if (w_arm) r_wbank <= ~r_wbank;
    end
  always_comb begin
    w_state_nx = (w_arm || (r_state == RUN && !w_rlast)) ? RUN : IDLE;
    w_rcnt_nx  = (w_arm || r_state == IDLE) ? '0 : r_rcnt + 1'b1;
    w_rbank_nx = w_arm ? r_wbank : r_rbank;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      {valid_o, sof_o, bin_o, xr_o, xi_o, yr_o, yi_o} <= '0;
    end else if (ce) begin
      valid_o <= r_state == RUN;
      sof_o   <= (r_state == RUN) && (r_rcnt == '0);
      if (r_state == RUN) begin
        bin_o        <= r_rcnt;
        {xr_o, xi_o} <= w_rd0[r_rbank];
        {yr_o, yi_o} <= w_rd1[r_rbank];
      end
    end
endmodule

// File: tb/tb_fft32_reorder.sv
// tb_fft32_reorder: randomized bench checking fft32_reorder against a queue-based frame model
module tb_fft32_reorder;
  localparam int W = 8, L = 5, NB = 16;
  logic CLK = 0, RST = 1, ce = 0, valid_i = 0;
  logic [W-1:0] xr = 0, xi = 0, yr = 0, yi = 0;
  logic valid_o, sof_o;
  logic [L-2:0] bin_o;
  logic [W-1:0] xr_o, xi_o, yr_o, yi_o;
  int total = 0, bad = 0, phase = 0, cnt = 0, run = 0, maxrun = 0;
  typedef struct {int bin; logic [W-1:0] xr, xi, yr, yi;} beat_t;
  beat_t q[$];
  beat_t mb;
  logic [W-1:0] fr_r [32];
  logic [W-1:0] fr_i [32];
  int n = 0, arm_q = 0;
  bit arm_ev = 0, ce_edge = 0;
  logic e_v = 0, e_s = 0;
  logic [L-2:0] e_b = 0;
  logic [W-1:0] e_xr = 0, e_xi = 0, e_yr = 0, e_yi = 0;

  fft32_reorder #(.width(W), .log2n(L)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi),
    .valid_o(valid_o), .sof_o(sof_o), .bin_o(bin_o),
    .xr_o(xr_o), .xi_o(xi_o), .yr_o(yr_o), .yi_o(yi_o)
  );

  always #5 CLK = ~CLK;

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < L; i++) if (v[i]) r |= 1 << (L - 1 - i);
    return r;
  endfunction

  // Model: a completed frame becomes 16 natural-order beats; each ce edge emits the next pending one.
  always @(posedge CLK or negedge RST) begin
    arm_ev = 0;
    if (!RST) begin
      q.delete();
      n = 0;
      ce_edge = 0;
      {e_v, e_s, e_b, e_xr, e_xi, e_yr, e_yi} = '0;
    end else begin
      ce_edge = ce;
      if (ce) begin
        if (q.size() > 0) begin
          mb = q.pop_front();
          e_v = 1; e_s = (mb.bin == 0); e_b = 4'(mb.bin);
          e_xr = mb.xr; e_xi = mb.xi; e_yr = mb.yr; e_yi = mb.yi;
        end else begin
          e_v = 0; e_s = 0;
        end
        if (valid_i) begin
          fr_r[brev(2*n)] = xr; fr_i[brev(2*n)] = xi;
          fr_r[brev(2*n+1)] = yr; fr_i[brev(2*n+1)] = yi;
          n++;
          if (n == NB) begin
            n = 0;
            arm_ev = 1;
            arm_q = q.size();
            for (int m = 0; m < NB; m++)
              q.push_back('{m, fr_r[2*m], fr_i[2*m], fr_r[2*m+1], fr_i[2*m+1]});
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic mon();
    forever begin
      @(negedge CLK);
      total++;
      if ({valid_o, sof_o, bin_o, xr_o, xi_o, yr_o, yi_o} !== {e_v, e_s, e_b, e_xr, e_xi, e_yr, e_yi}) begin
        bad++;
        $display("FAIL out @%0t got v=%0b s=%0b b=%0d x=%0d,%0d y=%0d,%0d exp v=%0b s=%0b b=%0d x=%0d,%0d y=%0d,%0d",
          $time, valid_o, sof_o, bin_o, xr_o, xi_o, yr_o, yi_o, e_v, e_s, e_b, e_xr, e_xi, e_yr, e_yi);
      end
      if (arm_ev) begin
        total++;
        if (arm_q != 0) begin
          bad++;
          $display("FAIL overrun pending=%0d exp=0", arm_q);
        end
      end
      if ((phase == 1 || phase == 3) && valid_o && ce_edge) begin
        total++;
        if (int'(xr_o) != 2*int'(bin_o) || int'(yr_o) != 2*int'(bin_o)+1 ||
            int'(xi_o) != 2*int'(bin_o)+64 || sof_o != (bin_o == 0)) begin
          bad++;
          $display("FAIL bins b=%0d got x=%0d,%0d y=%0d s=%0b", bin_o, xr_o, xi_o, yr_o, sof_o);
        end
      end
      if (valid_o && ce_edge && RST) begin
        cnt++; run++;
        if (run > maxrun) maxrun = run;
      end else if (ce_edge) run = 0;
    end
  endtask

  task automatic tick(input bit stall);
    @(posedge CLK);
    #2;
    ce = stall ? ($urandom_range(0, 9) < 7) : 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, b, c, d, input bit stall);
    valid_i = 1;
    {xr, xi, yr, yi} = {a, b, c, d};
    for (int g = 0; g < 1000; g++) begin
      @(posedge CLK);
      if (ce) break;
      #2;
      ce = $urandom_range(0, 9) < 7;
    end
    #2;
    valid_i = 0;
    ce = stall ? ($urandom_range(0, 9) < 7) : 1'b1;
  endtask

  task automatic frame(input int mode, input int k, input bit gap, input bit stall, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      logic [W-1:0] a, c;
      a = 8'(brev(2*i));
      c = 8'(brev(2*i+1));
      if (mode == 2) begin a = 8'($urandom); c = 8'($urandom); end
      send(a, mode == 1 ? 8'(16*k + i) : mode == 0 ? a + 8'd64 : 8'($urandom),
           c, mode == 0 ? c + 8'd64 : 8'($urandom), stall);
      if (gap) repeat ($urandom_range(0, 5)) tick(stall);
    end
  endtask

  task automatic drain(input bit stall, input int cycles);
    repeat (cycles) tick(stall);
    ce = 1;
  endtask

  task automatic start(input int p);
    phase = p; cnt = 0; run = 0; maxrun = 0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1 RST = 0;
    #1 chk("rst_async", {valid_o, sof_o, bin_o, xr_o, xi_o, yr_o, yi_o}, 0);
    tick(0);
    tick(0);
    RST = 1;
  endtask

  initial begin
    fork mon(); join_none
    #1 RST = 0;
    @(negedge CLK);
    chk("rst_ctl", {valid_o, sof_o, bin_o}, 0);
    chk("rst_data", {xr_o, xi_o, yr_o, yi_o}, 0);
    tick(0);
    RST = 1;
    tick(0);

    start(1);
    frame(0, 0, 0, 0, NB);
    @(negedge CLK);
    chk("lat_not_yet", valid_o, 0);
    @(negedge CLK);
    chk("first_ctl", {valid_o, sof_o, bin_o}, {1'b1, 1'b1, 4'd0});
    chk("first_data", {xr_o, xi_o, yr_o, yi_o}, {8'd0, 8'd64, 8'd1, 8'd65});
    drain(0, 30);
    chk("single_cnt", cnt, 16);
    chk("single_run", maxrun, 16);

    start(2);
    for (int k = 0; k < 3; k++) frame(1, k, 0, 0, NB);
    drain(0, 30);
    chk("b2b_cnt", cnt, 48);
    chk("b2b_run", maxrun, 48);

    start(3);
    frame(0, 0, 1, 0, NB);
    drain(0, 30);
    chk("gap_cnt", cnt, 16);
    chk("gap_run", maxrun, 16);

    start(4);
    ce = 0;
    frame(2, 0, 0, 1, NB);
    frame(2, 1, 0, 1, NB);
    drain(1, 60);
    drain(0, 30);
    chk("stall_cnt", cnt, 32);
    chk("stall_run", maxrun, 32);

    start(5);
    frame(2, 0, 0, 0, NB);
    begin
      bit found = 0;
      for (int g = 0; g < 100 && !found; g++) begin
        @(negedge CLK);
        if (valid_o && bin_o == 7) found = 1;
      end
      chk("beat7_seen", found, 1);
    end
    pulse_reset();
    cnt = 0; run = 0; maxrun = 0;
    drain(0, 20);
    chk("after_rst_quiet", cnt, 0);
    frame(2, 0, 0, 0, NB);
    drain(0, 30);
    chk("rst_read_cnt", cnt, 16);
    chk("rst_read_run", maxrun, 16);

    start(6);
    frame(2, 0, 0, 0, 10);
    drain(0, 5);
    pulse_reset();
    cnt = 0; run = 0; maxrun = 0;
    frame(0, 0, 0, 0, NB);
    drain(0, 30);
    chk("partial_cnt", cnt, 16);
    chk("partial_run", maxrun, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
